adbg_or1k_spr_arbiter: RTL and testbench

//   Shares one OR1K SPR bus (cpu_addr_o/cpu_data_o/cpu_stb_o/cpu_we_o/cpu_ack_i) among NREQ requesters
//   (debug BIU, trace unit, etc.). Fair round-robin, one transfer in flight.

---
 rtl/adbg_or1k_spr_arb_pkg.sv | 19 +
 rtl/adbg_rr_arbiter.sv | 30 +++
 rtl/adbg_or1k_spr_arbiter.sv | 152 +++++++++++++++
 tb/tb_adbg_or1k_spr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_or1k_spr_arb_pkg.sv
// Shared types and defaults for the OR1K SPR bus arbiter slice.
package adbg_or1k_spr_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned SPR_AW_DEF      = 32;
  localparam int unsigned SPR_DW_DEF      = 32;
  localparam int unsigned SPR_TIMEOUT_DEF = 255;

  // Width needed to hold a count of 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adbg_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr_i, wrapping.
module adbg_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PW'((32'(ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/adbg_or1k_spr_arbiter.sv
// Round-robin arbiter sharing one OR1K SPR bus among NREQ requesters.
// Optional XFER timeout enabled by defining ADBG_SPR_ARB_TIMEOUT_EN.
module adbg_or1k_spr_arbiter
  import adbg_or1k_spr_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned AW             = SPR_AW_DEF,
  parameter int unsigned DW             = SPR_DW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = SPR_TIMEOUT_DEF
) (
  input  logic               cpu_clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    ack_o,
  output logic [NREQ-1:0]    err_o,
  output logic [DW-1:0]      rdata_o,
  output logic [AW-1:0]      cpu_addr_o,
  output logic [DW-1:0]      cpu_data_o,
  output logic               cpu_stb_o,
  output logic               cpu_we_o,
  input  logic               cpu_ack_i,
  input  logic [DW-1:0]      cpu_data_i
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [PW-1:0]   gnt_idx;

`ifdef ADBG_SPR_ARB_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] err_q, err_d;
`endif

  adbg_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // One-hot grant is OR-muxed so an empty grant yields zero on the bus.
  always_comb begin
    cpu_addr_o = '0;
    cpu_data_o = '0;
    cpu_we_o   = 1'b0;
    gnt_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) begin
        cpu_addr_o = cpu_addr_o | addr_i[k*AW +: AW];
        cpu_data_o = cpu_data_o | wdata_i[k*DW +: DW];
        cpu_we_o   = cpu_we_o | we_i[k];
        gnt_idx    = PW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (cpu_ack_i) begin
          if (!cpu_we_o) rdata_d = cpu_data_i;
          ack_d   = gnt_q;
          ptr_d   = gnt_idx;
          state_d = ARB_DONE;
        end
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = gnt_q;
          rdata_d = '0;
          ptr_d   = gnt_idx;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ARB_DONE: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign cpu_stb_o = (state_q == ARB_XFER);
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = '0;
`endif

endmodule

// File: tb/tb_adbg_or1k_spr_arbiter.sv
// Directed self-checking bench for adbg_or1k_spr_arbiter (NREQ=2, TIMEOUT_CYCLES=4).
module tb_adbg_or1k_spr_arbiter;

  logic        cpu_clk_i;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;
  logic [31:0] cpu_addr_o;
  logic [31:0] cpu_data_o;
  logic        cpu_stb_o;
  logic        cpu_we_o;
  logic        cpu_ack_i;
  logic [31:0] cpu_data_i;

  int vectors;
  int miscompares;

  adbg_or1k_spr_arbiter #(
    .NREQ           (2),
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .cpu_clk_i  (cpu_clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .cpu_addr_o (cpu_addr_o),
    .cpu_data_o (cpu_data_o),
    .cpu_stb_o  (cpu_stb_o),
    .cpu_we_o   (cpu_we_o),
    .cpu_ack_i  (cpu_ack_i),
    .cpu_data_i (cpu_data_i)
  );

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  task automatic tick();
    @(posedge cpu_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] seq [4];
    int n;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    vectors = 0;
    miscompares = 0;
    rst_i = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    cpu_ack_i = 1'b0; cpu_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_gnt",   32'(gnt_o), 32'h0);
    chk("rst_ack",   32'(ack_o), 32'h0);
    chk("rst_err",   32'(err_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_stb",   32'(cpu_stb_o), 32'h0);

    // 1: single read from requester 0, ack after three XFER cycles
    req_i = 2'b01; we_i = 2'b00; addr_i = {32'h0, 32'h0000_2801};
    tick();
    chk("t1_stb1",  32'(cpu_stb_o), 32'h1);
    chk("t1_gnt",   32'(gnt_o), 32'h1);
    chk("t1_addr",  cpu_addr_o, 32'h0000_2801);
    chk("t1_we",    32'(cpu_we_o), 32'h0);
    tick();
    chk("t1_stb2",  32'(cpu_stb_o), 32'h1);
    chk("t1_noack", 32'(ack_o), 32'h0);
    tick();
    chk("t1_stb3",  32'(cpu_stb_o), 32'h1);
    cpu_ack_i = 1'b1; cpu_data_i = 32'hDEAD_BEEF;
    tick();
    cpu_ack_i = 1'b0; cpu_data_i = 32'h0;
    chk("t1_stb_off", 32'(cpu_stb_o), 32'h0);
    chk("t1_ack",     32'(ack_o), 32'h1);
    chk("t1_rdata",   rdata_o, 32'hDEAD_BEEF);
    chk("t1_gnt_done", 32'(gnt_o), 32'h1);
    req_i = 2'b00;
    tick();
    chk("t1_ack_clr", 32'(ack_o), 32'h0);
    chk("t1_gnt_clr", 32'(gnt_o), 32'h0);
    chk("t1_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // 2: both requesting continuously, single-cycle acks, fresh pointer
    rst_i = 1'b1; #2; rst_i = 1'b0;
    req_i = 2'b11; cpu_ack_i = 1'b1; cpu_data_i = 32'h0000_00A5;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t2_xfer_gnt", 32'(gnt_o), 32'(seq[t]));
      chk("t2_xfer_stb", 32'(cpu_stb_o), 32'h1);
      tick();
      chk("t2_done_ack", 32'(ack_o), 32'(seq[t]));
      chk("t2_done_stb", 32'(cpu_stb_o), 32'h0);
      tick();
      chk("t2_idle_gnt", 32'(gnt_o), 32'h0);
      chk("t2_idle_ack", 32'(ack_o), 32'h0);
    end
    chk("t2_rdata", rdata_o, 32'h0000_00A5);

    // 3: write from requester 1, ack in the first XFER cycle
    req_i = 2'b10; we_i = 2'b10;
    addr_i = {32'h0000_3000, 32'h0000_2801};
    wdata_i = {32'h1234_5678, 32'h0};
    cpu_data_i = 32'hCAFE_F00D;
    tick();
    chk("t3_gnt",  32'(gnt_o), 32'h2);
    chk("t3_we",   32'(cpu_we_o), 32'h1);
    chk("t3_data", cpu_data_o, 32'h1234_5678);
    chk("t3_addr", cpu_addr_o, 32'h0000_3000);
    tick();
    chk("t3_ack",   32'(ack_o), 32'h2);
    chk("t3_rdata", rdata_o, 32'h0000_00A5);
    req_i = 2'b00; we_i = 2'b00; cpu_ack_i = 1'b0; cpu_data_i = 32'h0;
    tick();
    chk("t3_idle", 32'(gnt_o), 32'h0);

    // 4: timeout behaviour
`ifdef ADBG_SPR_ARB_TIMEOUT_EN
    req_i = 2'b01;
    tick();
    n = 0;
    for (int i = 0; i < 10 && cpu_stb_o; i++) begin
      n++;
      tick();
    end
    chk("t4_stb_len", 32'(n), 32'd4);
    chk("t4_err",   32'(err_o), 32'h1);
    chk("t4_ack",   32'(ack_o), 32'h0);
    chk("t4_rdata", rdata_o, 32'h0);
    req_i = 2'b00;
    tick();
    chk("t4_err_clr", 32'(err_o), 32'h0);
    req_i = 2'b01;
    tick(); tick(); tick(); tick();
    chk("t4b_stb4", 32'(cpu_stb_o), 32'h1);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h5A5A_5A5A;
    tick();
    cpu_ack_i = 1'b0; cpu_data_i = 32'h0;
    chk("t4b_ack",   32'(ack_o), 32'h1);
    chk("t4b_err",   32'(err_o), 32'h0);
    chk("t4b_rdata", rdata_o, 32'h5A5A_5A5A);
    req_i = 2'b00;
    tick();
`else
    req_i = 2'b01;
    tick();
    n = 0;
    for (int i = 0; i < 8 && cpu_stb_o; i++) begin
      if (err_o != 2'b00) n++;
      tick();
    end
    chk("t4_stb_held", 32'(cpu_stb_o), 32'h1);
    chk("t4_err_seen", 32'(n), 32'd0);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h5A5A_5A5A;
    tick();
    cpu_ack_i = 1'b0; cpu_data_i = 32'h0;
    chk("t4_ack",   32'(ack_o), 32'h1);
    chk("t4_err",   32'(err_o), 32'h0);
    chk("t4_rdata", rdata_o, 32'h5A5A_5A5A);
    req_i = 2'b00;
    tick();
`endif

    // 5: asynchronous reset in the middle of a transfer
    req_i = 2'b10;
    tick();
    chk("t5_pre_stb", 32'(cpu_stb_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_rst_stb",   32'(cpu_stb_o), 32'h0);
    chk("t5_rst_gnt",   32'(gnt_o), 32'h0);
    chk("t5_rst_rdata", rdata_o, 32'h0);
    req_i = 2'b11;
    tick();
    chk("t5_rst_ack", 32'(ack_o), 32'h0);
    rst_i = 1'b0;
    req_i = 2'b01;
    tick();
    chk("t5_first_gnt", 32'(gnt_o), 32'h1);

    // 6: requester 1 rises while requester 0 is in XFER
    req_i = 2'b11;
    tick();
    chk("t6_hold_gnt", 32'(gnt_o), 32'h1);
    chk("t6_hold_stb", 32'(cpu_stb_o), 32'h1);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h0000_0777;
    tick();
    chk("t6_ack0", 32'(ack_o), 32'h1);
    req_i = 2'b10; cpu_ack_i = 1'b0;
    tick();
    chk("t6_idle_gnt", 32'(gnt_o), 32'h0);
    tick();
    chk("t6_gnt1", 32'(gnt_o), 32'h2);
    chk("t6_stb1", 32'(cpu_stb_o), 32'h1);
    cpu_ack_i = 1'b1;
    tick();
    chk("t6_ack1", 32'(ack_o), 32'h2);
    chk("t6_rdata", rdata_o, 32'h0000_0777);
    req_i = 2'b00; cpu_ack_i = 1'b0;
    tick();
    chk("t6_end_gnt", 32'(gnt_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
